// File: rtl/rt_preload_pkg.sv
// Shared types for the racetrack data-memory preloader.
//   state_e        : loader FSM states
//   err_code_e     : values reported on err_code_o
//   BYTES_PER_WORD : bytes packed into one port-B word
//   bytes_to_words : ceil(n / 4) without overflowing the 32-bit byte count
package rt_preload_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ISSUE,
        ST_WAIT_VALID,
        ST_GAP,
        ST_DRAIN,
        ST_DONE,
        ST_ERROR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_OVERSIZE = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } err_code_e;

    // Widen before adding 3 so a byte count near 2^32 cannot wrap to a small word count.
    function automatic logic [30:0] bytes_to_words(input logic [31:0] num_bytes);
        logic [32:0] sum;
        sum = {1'b0, num_bytes} + 33'd3;
        return sum[32:2];
    endfunction

endpackage

// File: rtl/rt_byte_packer.sv
// Little-endian byte-lane assembler for one 32-bit word.
//   clk_i, rst_ni  : clock, async active-low reset
//   clear_i        : zero the word and restart at lane 0
//   fill_en_i      : stream ready (bytes are accepted only while set)
//   last_word_i    : current word is the final word of the image
//   last_len_i     : bytes in the final word (0 means a full word)
//   s_valid_i/s_data_i : byte stream
//   word_done_c    : the byte accepted this cycle completes the word
//   word_o         : assembled word, unfilled lanes read as 0
module rt_byte_packer
    import rt_preload_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          fill_en_i,
    input  logic                          last_word_i,
    input  logic [$clog2(BYTES_PER_WORD)-1:0] last_len_i,
    input  logic                          s_valid_i,
    input  logic [BYTE_W-1:0]             s_data_i,
    output logic                          word_done_c,
    output logic [WORD_W-1:0]             word_o
);

    localparam int unsigned LANE_W = $clog2(BYTES_PER_WORD);
    localparam int unsigned CNT_W  = LANE_W + 1;

    logic [LANE_W-1:0] lane_q;
    logic [WORD_W-1:0] word_q;
    logic [CNT_W-1:0]  word_len;
    logic [CNT_W-1:0]  lane_next;
    logic              accept;

    // Bytes expected in this word: short only for the padded tail of the image.
    always_comb begin
        word_len = CNT_W'(BYTES_PER_WORD);
        if (last_word_i && (last_len_i != '0)) begin
            word_len = {1'b0, last_len_i};
        end
    end

    assign accept      = fill_en_i && s_valid_i;
    assign lane_next   = {1'b0, lane_q} + CNT_W'(1);
    assign word_done_c = accept && (lane_next == word_len);
    assign word_o      = word_q;

    // Byte k of the word lands in bits [8k+7:8k].
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= '0;
            word_q <= '0;
        end else if (clear_i) begin
            lane_q <= '0;
            word_q <= '0;
        end else if (accept) begin
            word_q[{lane_q, 3'b000} +: BYTE_W] <= s_data_i;
            lane_q                             <= lane_next[LANE_W-1:0];
        end
    end

endmodule

// File: rtl/rt_mem_preloader.sv
// Firmware loader for the racetrack LiM data memory (port B).
// Packs a little-endian byte stream into words, writes each word over port B
// and waits for rvalid before the next, then drains and enables core fetch.
//   clk_i, rst_ni                 : clock, async active-low reset
//   start_i, base_addr_i, num_bytes_i : load request (accepted in IDLE/DONE/ERROR)
//   s_valid_i, s_data_i, s_ready_o    : byte stream
//   en_b_o, we_b_o, be_b_o, addr_b_o, wdata_b_o, rvalid_b_i : port B
//   lim_funct_o, we_funct_o, addr_range_o : LiM controls, held neutral
//   busy_o, done_o, fetch_enable_o, err_o, err_code_o : status
module rt_mem_preloader
    import rt_preload_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 22,
    parameter int unsigned MAX_WORDS      = 64000,
    parameter int unsigned LIM_FUNCT_W    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned DRAIN_CYCLES   = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [RAM_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [31:0]               num_bytes_i,
    input  logic                      s_valid_i,
    input  logic [7:0]                s_data_i,
    output logic                      s_ready_o,
    output logic                      en_b_o,
    output logic                      we_b_o,
    output logic [3:0]                be_b_o,
    output logic [RAM_ADDR_WIDTH-1:0] addr_b_o,
    output logic [31:0]               wdata_b_o,
    output logic [LIM_FUNCT_W-1:0]    lim_funct_o,
    output logic                      we_funct_o,
    output logic [RAM_ADDR_WIDTH-1:0] addr_range_o,
    input  logic                      rvalid_b_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      fetch_enable_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o
);

    localparam int unsigned RW      = RAM_ADDR_WIDTH;
    localparam int unsigned LANE_W  = $clog2(BYTES_PER_WORD);
    localparam int unsigned WORDS_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    // DRAIN_CYCLES is expected to be at least 1.
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    state_e              state_q, state_d;
    logic [RW-1:0]       addr_q, addr_d;
    logic [WORDS_W-1:0]  words_left_q, words_left_d;
    logic [LANE_W-1:0]   last_len_q, last_len_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    err_code_e           err_code_q, err_code_d;
    logic [30:0]         words_req;
    logic                clear_c;

    logic                s_ready_q;
    logic                en_q;
    logic                be_on_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic                word_done_c;
    logic [WORD_W-1:0]   word;
    logic                unused_base_lsbs;

    // Word addresses only: the two byte-offset bits of the base are dropped.
    assign unused_base_lsbs = ^base_addr_i[1:0];

    rt_byte_packer u_packer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_c),
        .fill_en_i   (s_ready_q),
        .last_word_i (words_left_q == WORDS_W'(1)),
        .last_len_i  (last_len_q),
        .s_valid_i   (s_valid_i),
        .s_data_i    (s_data_i),
        .word_done_c (word_done_c),
        .word_o      (word)
    );

    // Next-state and counter update logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        last_len_d   = last_len_q;
        tmo_d        = tmo_q;
        drain_d      = drain_q;
        err_code_d   = err_code_q;
        clear_c      = 1'b0;
        words_req    = bytes_to_words(num_bytes_i);

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    clear_c    = 1'b1;
                    addr_d     = {base_addr_i[RW-1:2], 2'b00};
                    last_len_d = num_bytes_i[LANE_W-1:0];
                    err_code_d = ERR_NONE;
                    tmo_d      = '0;
                    drain_d    = '0;
                    if (words_req > 31'(MAX_WORDS)) begin
                        state_d      = ST_ERROR;
                        err_code_d   = ERR_OVERSIZE;
                        words_left_d = '0;
                    end else if (words_req == '0) begin
                        state_d      = ST_DRAIN;
                        words_left_d = '0;
                    end else begin
                        state_d      = ST_FILL;
                        words_left_d = WORDS_W'(words_req);
                    end
                end
            end
            ST_FILL: begin
                if (word_done_c) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_VALID;
                tmo_d   = '0;
            end
            ST_WAIT_VALID: begin
                // rvalid wins over an expiry in the same cycle.
                if (rvalid_b_i) begin
                    state_d = ST_GAP;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_GAP: begin
                clear_c      = 1'b1;
                addr_d       = addr_q + RW'(BYTES_PER_WORD);
                words_left_d = words_left_q - WORDS_W'(1);
                drain_d      = '0;
                state_d      = (words_left_q == WORDS_W'(1)) ? ST_DRAIN : ST_FILL;
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs (outputs decoded from next state).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            last_len_q   <= '0;
            tmo_q        <= '0;
            drain_q      <= '0;
            err_code_q   <= ERR_NONE;
            s_ready_q    <= 1'b0;
            en_q         <= 1'b0;
            be_on_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            last_len_q   <= last_len_d;
            tmo_q        <= tmo_d;
            drain_q      <= drain_d;
            err_code_q   <= err_code_d;
            s_ready_q    <= (state_d == ST_FILL);
            en_q         <= (state_d == ST_ISSUE);
            be_on_q      <= (state_d == ST_ISSUE);
            busy_q       <= state_d inside {ST_FILL, ST_ISSUE, ST_WAIT_VALID, ST_GAP, ST_DRAIN};
            done_q       <= (state_d == ST_DONE);
            err_q        <= (state_d == ST_ERROR);
        end
    end

    assign s_ready_o      = s_ready_q;
    assign en_b_o         = en_q;
    assign we_b_o         = en_q;
    assign be_b_o         = {4{be_on_q}};
    assign addr_b_o       = addr_q;
    assign wdata_b_o      = word;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign fetch_enable_o = done_q;
    assign err_o          = err_q;
    assign err_code_o     = err_code_q;

    // LiM controls stay neutral while the image is loaded.
    assign lim_funct_o    = '0;
    assign we_funct_o     = 1'b0;
    assign addr_range_o   = '0;

endmodule

// File: tb/tb_rt_mem_preloader.sv
// Directed bench for rt_mem_preloader: drives a byte stream and a port-B
// responder, records issued writes and checks them against hand-computed values.
module tb_rt_mem_preloader;

    localparam int unsigned RW   = 22;
    localparam int unsigned MAXW = 64000;
    localparam int unsigned TMO  = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [RW-1:0] base_addr = '0;
    logic [31:0] num_bytes = '0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic        en_b, we_b;
    logic [3:0]  be_b;
    logic [RW-1:0] addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  lim_funct;
    logic        we_funct;
    logic [RW-1:0] addr_range;
    logic        rvalid_b = 1'b0;
    logic        busy, done, fetch_en, err;
    logic [1:0]  err_code;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int          en_total = 0;
    int          en_double = 0;
    logic        en_prev = 1'b0;

    logic [31:0] wr_addr [8];
    logic [31:0] wr_data [8];
    logic [3:0]  wr_be   [8];
    int          n_wr;
    int unsigned rv_cyc, fe_cyc, err_cyc, en_cyc;
    int          en_before;

    rt_mem_preloader #(
        .RAM_ADDR_WIDTH (RW),
        .MAX_WORDS      (MAXW),
        .LIM_FUNCT_W    (3),
        .TIMEOUT_CYCLES (TMO),
        .DRAIN_CYCLES   (3)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .base_addr_i    (base_addr),
        .num_bytes_i    (num_bytes),
        .s_valid_i      (s_valid),
        .s_data_i       (s_data),
        .s_ready_o      (s_ready),
        .en_b_o         (en_b),
        .we_b_o         (we_b),
        .be_b_o         (be_b),
        .addr_b_o       (addr_b),
        .wdata_b_o      (wdata_b),
        .lim_funct_o    (lim_funct),
        .we_funct_o     (we_funct),
        .addr_range_o   (addr_range),
        .rvalid_b_i     (rvalid_b),
        .busy_o         (busy),
        .done_o         (done),
        .fetch_enable_o (fetch_en),
        .err_o          (err),
        .err_code_o     (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Port-B enable bookkeeping: total pulses and back-to-back occurrences.
    always @(negedge clk) begin
        if (en_b && en_prev) en_double = en_double + 1;
        if (en_b) en_total = en_total + 1;
        en_prev = en_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one load: streams bytes 1,2,3,... and answers each en pulse with a
    // one-cycle rvalid 'delay' cycles later (delay < 0: never answer).
    task automatic do_load(input logic [31:0] nb, input logic [RW-1:0] base,
                           input bit toggle, input int delay, input bit inject);
        int idx, cd, guard;
        bit armed, sent, pend_start, inj;
        n_wr = 0; idx = 0; cd = 0; guard = 0;
        armed = 0; pend_start = 0; inj = inject;
        rv_cyc = 0; fe_cyc = 0; err_cyc = 0; en_cyc = 0;
        num_bytes = nb; base_addr = base; start = 1'b1;
        tick();
        start = 1'b0;
        while (!done && !err && guard < 4000) begin
            sent = 0; s_valid = 1'b0; rvalid_b = 1'b0; start = 1'b0;
            if (s_ready && (idx < int'(nb)) && (!toggle || cyc[0])) begin
                s_valid = 1'b1;
                s_data  = 8'(idx + 1);
                sent    = 1;
            end
            if (armed) begin
                cd--;
                if (cd == 0) begin
                    rvalid_b = 1'b1;
                    armed    = 0;
                    rv_cyc   = cyc;
                end
            end
            if (pend_start) begin
                start      = 1'b1;
                num_bytes  = 32'd0;
                pend_start = 0;
            end
            tick();
            guard++;
            if (sent) idx++;
            if (en_b) begin
                if (n_wr < 8) begin
                    wr_addr[n_wr] = 32'(addr_b);
                    wr_data[n_wr] = wdata_b;
                    wr_be[n_wr]   = be_b;
                end
                n_wr++;
                en_cyc = cyc;
                if (delay >= 0) begin
                    armed = 1;
                    cd    = delay + 1;
                end
                if (inj) begin
                    pend_start = 1;
                    inj        = 0;
                end
            end
        end
        s_valid = 1'b0; rvalid_b = 1'b0; start = 1'b0;
        if (done) fe_cyc = cyc;
        if (err) err_cyc = cyc;
        check("load_terminated", 32'(done | err), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_done",     32'(done), 32'd0);
        check("rst_fetch",    32'(fetch_en), 32'd0);
        check("rst_err",      32'({err, err_code}), 32'd0);
        check("rst_portb",    32'({en_b, we_b, be_b, s_ready}), 32'd0);
        check("rst_addr",     32'(addr_b), 32'd0);
        check("rst_wdata",    wdata_b, 32'd0);
        check("rst_lim",      32'({lim_funct, we_funct}), 32'd0);
        check("rst_range",    32'(addr_range), 32'd0);
        rst_n = 1'b1;
        tick();

        // 8 bytes at base 0, rvalid 5 cycles after each en
        do_load(32'd8, 22'h0, 1'b0, 5, 1'b0);
        check("t1_nwr",   32'(n_wr), 32'd2);
        check("t1_addr0", wr_addr[0], 32'h0);
        check("t1_data0", wr_data[0], 32'h04030201);
        check("t1_be0",   32'(wr_be[0]), 32'hF);
        check("t1_addr1", wr_addr[1], 32'h4);
        check("t1_data1", wr_data[1], 32'h08070605);
        // rvalid cycle, GAP, three drain cycles, then fetch enable
        check("t1_fe_lat", fe_cyc - rv_cyc, 32'd5);
        check("t1_fetch", 32'(fetch_en), 32'd1);
        check("t1_busy",  32'({busy, err}), 32'd0);
        check("t1_lim",   32'({lim_funct, we_funct, addr_range}), 32'd0);

        // 6 bytes, unaligned base: padded tail word, low address bits ignored
        do_load(32'd6, 22'h103, 1'b0, 5, 1'b0);
        check("t2_nwr",   32'(n_wr), 32'd2);
        check("t2_addr0", wr_addr[0], 32'h100);
        check("t2_addr1", wr_addr[1], 32'h104);
        check("t2_data1", wr_data[1], 32'h00000605);
        check("t2_be1",   32'(wr_be[1]), 32'hF);
        check("t2_done",  32'(done), 32'd1);

        // Empty image: straight to drain, no port-B traffic
        en_before = en_total;
        num_bytes = 32'd0; base_addr = 22'h0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_done_clr", 32'(done), 32'd0);
        check("t3_busy",     32'(busy), 32'd1);
        tick();
        tick();
        check("t3_fetch_early", 32'(fetch_en), 32'd0);
        tick();
        check("t3_done",  32'({done, fetch_en}), 32'h3);
        check("t3_no_en", 32'(en_total), 32'(en_before));

        // Oversize image: error the cycle after start, no writes
        en_before = en_total;
        num_bytes = MAXW * 4 + 1; start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_err",      32'(err), 32'd1);
        check("t4_code",     32'(err_code), 32'd1);
        check("t4_busy",     32'({busy, done, fetch_en}), 32'd0);
        repeat (20) tick();
        check("t4_no_en",    32'(en_total), 32'(en_before));

        // Exactly MAX_WORDS words is accepted; abort it with a reset
        num_bytes = MAXW * 4; start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_accept",   32'({busy, err, s_ready}), 32'h5);
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst",      32'({busy, s_ready, err, err_code, done}), 32'd0);
        rst_n = 1'b1;
        tick();

        // No rvalid: timeout error after TIMEOUT_CYCLES wait cycles
        do_load(32'd4, 22'h10, 1'b0, -1, 1'b0);
        check("t6_nwr",   32'(n_wr), 32'd1);
        check("t6_code",  32'({err, err_code}), 32'h6);
        check("t6_lat",   err_cyc - en_cyc, 32'(TMO + 1));
        check("t6_fetch", 32'({fetch_en, done}), 32'd0);

        // Restart after error; rvalid in the final allowed wait cycle succeeds
        do_load(32'd4, 22'h20, 1'b0, int'(TMO), 1'b0);
        check("t7_done",  32'({done, fetch_en, err}), 32'h6);
        check("t7_code",  32'(err_code), 32'd0);
        check("t7_addr0", wr_addr[0], 32'h20);
        check("t7_data0", wr_data[0], 32'h04030201);

        // Toggling s_valid plus a start pulse during the wait
        do_load(32'd8, 22'h80, 1'b1, 5, 1'b1);
        check("t8_nwr",    32'(n_wr), 32'd2);
        check("t8_data0",  wr_data[0], 32'h04030201);
        check("t8_addr1",  wr_addr[1], 32'h84);
        check("t8_data1",  wr_data[1], 32'h08070605);
        check("t8_fe_lat", fe_cyc - rv_cyc, 32'd5);
        check("t8_en_dbl", 32'(en_double), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
